mux_select_sequencer: RTL
=========================

Name: mux_select_sequencer

Overview:
- Round-robin select generator sitting directly upstream of the 4:1 structural/behavioural multiplexer.
- Arbitrates four request lines and drives the mux select pair address1:address0, so the mux output carries exactly one granted source at a time.
- Holds each selection stable until the consumer signals done, and honours a minimum hold time.
- Pure control: the data inputs in0..in3 go straight to the mux and never pass through this block.

Parameters:
MIN_HOLD, 1, minimum cycles a grant stays asserted before done is honoured (legal 1..255)
TIMEOUT, 16, cycles after which a grant is force-released; used only with the optional feature (legal 2..255)

Ports:
clk  input  1  single clock; all state updates on rising edge
nreset  input  1  asynchronous, active-low reset
req0, req1, req2, req3  input  1 each  source requests for mux inputs in0..in3
done  input  1  consumer has taken the current selection; release grant
address0  output  1  mux select bit 0 (registered)
address1  output  1  mux select bit 1 (registered)
sel_valid  output  1  high while a grant is active; mux output meaningful only then
grant  output  4  one-hot grant, bit i = source i selected (registered)
timeout_flag  output  1  one-cycle pulse on forced release (tied 0 without the optional feature)

Behaviour:
- Reset (nreset low, asynchronous, any cycle): state=IDLE, address1:address0=00, sel_valid=0, grant=0000, last-grant pointer=3 (source 0 has top priority after reset), hold counter=0, timeout_flag=0.
- Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- FSM has two states: IDLE and GRANTED.
- IDLE, no request: outputs hold. The address retains its last value, sel_valid=0.
- IDLE, any req high at edge N:
  - The winner is the first requesting index searched from (pointer+1) mod 4 upward, wrapping at 3->0.
  - After edge N: address=winner, grant bit set, sel_valid=1, pointer=winner, hold counter=1, state=GRANTED.
  - Latency is one cycle from request sample to grant.
- GRANTED:
  - The hold counter increments each cycle and saturates at MIN_HOLD.
  - done is ignored while hold counter < MIN_HOLD. With MIN_HOLD=1, done is honoured on the first granted cycle.
  - The granted source dropping its req does not release the grant; only done (or timeout) releases it.
- Release (done=1 and counter>=MIN_HOLD at edge M):
  - Other requests pending: re-arbitrate in the same edge from the updated pointer and grant the new winner back-to-back. sel_valid stays 1, address changes after edge M, and the counter resets to 1.
  - The just-released source is lowest priority in this arbitration, even if it is still requesting.
  - No requests pending: state=IDLE, sel_valid=0, grant=0000; address holds.
- Outputs address1:address0 and grant always encode the same index whenever sel_valid=1. grant is 0000 whenever sel_valid=0.
- No combinational path from any input to any output.

Optional Feature:
- Macro: MUX_SELECT_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A watchdog counter (8-bit, cleared on every new grant) counts cycles in GRANTED.
  - On reaching TIMEOUT without an honoured done, the grant is force-released exactly as a done release would be, including back-to-back re-arbitration.
  - timeout_flag pulses high for one cycle after that edge.
  - done and timeout on the same edge count as a normal release: flag stays 0.
- Undefined: no watchdog logic; timeout_flag tied to 0; grants are held indefinitely until done.

Decomposition:
- Shared package (mux_pkg): SEL_W=2, NUM_SRC=4, state encoding constants (ST_IDLE=0, ST_GRANTED=1), reset pointer value 3.
- One sub-module: rr_pick4 is a combinational round-robin priority picker.
  - Inputs: 4-bit request vector, 2-bit pointer.
  - Outputs: 2-bit winner index and an any-request flag.
  - Instantiated once and used for both IDLE and back-to-back arbitration.

Test Plan:
- Reset then req2 only at cycle 3 -> after edge 3: address1:address0=10, grant=0100, sel_valid=1. done at cycle 5 -> IDLE with address still 10 and sel_valid=0.
- All four requests held high, done every cycle, MIN_HOLD=1 -> grants rotate 0,1,2,3,0 with sel_valid continuously 1 and no IDLE cycle.
- MIN_HOLD=3, req1 granted, done asserted on granted cycles 1 and 2 -> ignored. done on cycle 3 -> release.
- req0 and req3 high, pointer=3 after reset -> req0 wins. On release with both still high -> req3 granted, not req0.
- nreset pulsed low mid-grant between clock edges -> grant=0000, sel_valid=0 and address=00 immediately, with no clock edge needed.
- With MUX_SELECT_SEQUENCER_TIMEOUT_EN, TIMEOUT=4, req1 held and done never asserted -> force-release after 4 granted cycles, timeout_flag pulses one cycle, req1 re-granted next. Same test with macro undefined -> grant held for 50 cycles, timeout_flag=0 throughout.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the mux select sequencer: widths, FSM state
// encoding, the post-reset round-robin pointer and a one-hot helper.
// The optional watchdog is enabled with MUX_SELECT_SEQUENCER_TIMEOUT_EN.
package mux_pkg;

    localparam int SEL_W   = 2;
    localparam int NUM_SRC = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    // Pointer starts at the last source so source 0 wins first after reset.
    localparam logic [SEL_W-1:0] PTR_RESET = 2'd3;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_SRC-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_select_sequencer_if.sv
// Request/done inputs and select/grant outputs of the mux select sequencer.
// The sequencer sits on the slave modport; the request side drives master.
interface mux_select_sequencer_if;
    import mux_pkg::*;

    logic                req0;
    logic                req1;
    logic                req2;
    logic                req3;
    logic                done;
    logic                address0;
    logic                address1;
    logic                sel_valid;
    logic [NUM_SRC-1:0]  grant;
    logic                timeout_flag;

    modport master (
        output req0, req1, req2, req3, done,
        input  address0, address1, sel_valid, grant, timeout_flag
    );

    modport slave (
        input  req0, req1, req2, req3, done,
        output address0, address1, sel_valid, grant, timeout_flag
    );

endinterface

// File: rtl/mux_select_sequencer_rr_pick4.sv
// rr_pick4: combinational round-robin picker. The search starts at the
// index after ptr and wraps, so the source at ptr itself is always last.
module rr_pick4
    import mux_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               any_req
);

    // rot[k] is the request of the source k+1 positions after ptr.
    logic [NUM_SRC-1:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_rot
            localparam logic [SEL_W-1:0] OFS = SEL_W'(gi + 1);
            logic [SEL_W-1:0] idx;
            assign idx     = ptr + OFS;
            assign rot[gi] = req[idx];
        end
    endgenerate

    logic [SEL_W-1:0] offset;

    // Lowest set bit of the rotated vector gives the distance from ptr+1.
    always_comb begin
        offset = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = SEL_W'(k);
            end
        end
        winner  = ptr + offset + SEL_W'(1);
        any_req = |req;
    end

endmodule

// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer: round-robin grant generator driving the 4:1 mux
// select pair. A grant is held until done is honoured after MIN_HOLD
// cycles; on release the next requester is granted back-to-back.
// Define MUX_SELECT_SEQUENCER_TIMEOUT_EN to add a watchdog that force-
// releases a grant after TIMEOUT cycles and pulses timeout_flag.
module mux_select_sequencer
    import mux_pkg::*;
#(
    parameter int MIN_HOLD = 1,
    parameter int TIMEOUT  = 16
)
(
    input  logic               clk,
    input  logic               nreset,
    mux_select_sequencer_if.slave bus
);

    generate
        if (MIN_HOLD < 1 || MIN_HOLD > 255 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_params
            $error("mux_select_sequencer: MIN_HOLD must be 1..255 and TIMEOUT 2..255");
        end
    endgenerate

    localparam logic [7:0] MIN_HOLD_C = 8'(MIN_HOLD);

    state_t             state_reg,  state_next;
    logic [SEL_W-1:0]   addr_reg,   addr_next;
    logic [NUM_SRC-1:0] grant_reg,  grant_next;
    logic [SEL_W-1:0]   ptr_reg,    ptr_next;
    logic [7:0]         hold_reg,   hold_next;

    logic [NUM_SRC-1:0] req_vec;
    logic [SEL_W-1:0]   winner;
    logic               any_req;
    logic               do_grant;
    logic               done_ok;
    logic               timeout_hit;

    assign req_vec = {bus.req3, bus.req2, bus.req1, bus.req0};

    // The pointer always holds the current/last granted index, so the same
    // picker serves both IDLE arbitration and back-to-back re-arbitration,
    // and the released source naturally ends up lowest priority.
    rr_pick4 u_pick (
        .req     (req_vec),
        .ptr     (ptr_reg),
        .winner  (winner),
        .any_req (any_req)
    );

`ifdef MUX_SELECT_SEQUENCER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [7:0] wdog_reg, wdog_next;
    logic       tflag_reg, tflag_next;

    assign timeout_hit = (state_reg == ST_GRANTED) && (wdog_reg >= TIMEOUT_C);

    // Watchdog restarts on every new grant and saturates while granted.
    always_comb begin
        wdog_next  = wdog_reg;
        tflag_next = 1'b0;
        if (do_grant) begin
            wdog_next = 8'd1;
        end else if (state_reg == ST_GRANTED && wdog_reg != 8'hFF) begin
            wdog_next = wdog_reg + 8'd1;
        end
        if (timeout_hit && !done_ok) begin
            tflag_next = 1'b1;
        end
    end

    // Watchdog and forced-release flag registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wdog_reg  <= '0;
            tflag_reg <= 1'b0;
        end else begin
            wdog_reg  <= wdog_next;
            tflag_reg <= tflag_next;
        end
    end

    assign bus.timeout_flag = tflag_reg;
`else
    assign timeout_hit      = 1'b0;
    assign bus.timeout_flag = 1'b0;
`endif

    // Next-state logic: grant on request in IDLE, release on honoured done
    // or timeout, re-granting immediately when another request waits.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        hold_next  = hold_reg;
        do_grant   = 1'b0;
        done_ok    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                do_grant = any_req;
            end
            ST_GRANTED: begin
                if (hold_reg < MIN_HOLD_C) begin
                    hold_next = hold_reg + 8'd1;
                end
                done_ok = bus.done && (hold_reg >= MIN_HOLD_C);
                if (done_ok || timeout_hit) begin
                    if (any_req) begin
                        do_grant = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        grant_next = '0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
        if (do_grant) begin
            state_next = ST_GRANTED;
            addr_next  = winner;
            grant_next = onehot(winner);
            ptr_next   = winner;
            hold_next  = 8'd1;
        end
    end

    // State registers; reset clears the grant without waiting for a clock.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            grant_reg <= '0;
            ptr_reg   <= PTR_RESET;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            hold_reg  <= hold_next;
        end
    end

    assign bus.address0  = addr_reg[0];
    assign bus.address1  = addr_reg[1];
    assign bus.grant     = grant_reg;
    assign bus.sel_valid = (state_reg == ST_GRANTED);

endmodule
